// File: rtl/md_unit_iter.sv
// HI/LO multiply/divide unit: multiply ops complete after MUL_CYCLES cycles,
// divide is an iterative restoring divider (one quotient bit per cycle) plus a sign-fix cycle.
module md_unit_iter #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MTHI  = 4'd1;
    localparam logic [3:0] OP_MTLO  = 4'd2;
    localparam logic [3:0] OP_MULT  = 4'd3;
    localparam logic [3:0] OP_MULTU = 4'd4;
    localparam logic [3:0] OP_DIV   = 4'd5;
    localparam logic [3:0] OP_DIVU  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV_ITER, ST_DIV_FIX} state_e;

    state_e             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d;

    logic               issue_signed_s, mul_signed_s, quo_neg_s, rem_neg_s;
    logic [2*WIDTH-1:0] mul_a_ext_s, mul_b_ext_s, prod_s, hilo_s, mul_res_s;
    logic [WIDTH:0]     rem_shift_s, trial_s;
    logic [WIDTH-1:0]   quo_fix_s, rem_fix_s;

    assign busy = busy_q;
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

    // Datapath: sign-extended product (accumulate uses HI/LO, frozen while busy) and one divide step.
    always_comb begin
        issue_signed_s = (op == OP_DIV);
        mul_signed_s   = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
        mul_a_ext_s    = mul_signed_s ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        mul_b_ext_s    = mul_signed_s ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod_s         = mul_a_ext_s * mul_b_ext_s;
        hilo_s         = {hi_q, lo_q};
        case (op_q)
            OP_MADD, OP_MADDU: mul_res_s = hilo_s + prod_s;
            OP_MSUB, OP_MSUBU: mul_res_s = hilo_s - prod_s;
            default:           mul_res_s = prod_s;
        endcase
        rem_shift_s = {rem_q, quo_q[WIDTH-1]};
        trial_s     = rem_shift_s - {1'b0, dvs_q};
        quo_neg_s   = (op_q == OP_DIV) && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        rem_neg_s   = (op_q == OP_DIV) && a_q[WIDTH-1];
        quo_fix_s   = quo_neg_s ? -quo_q : quo_q;
        rem_fix_s   = rem_neg_s ? -rem_q : rem_q;
    end

    // Next-state logic for the control FSM and HI/LO.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    op_d = op;
                    a_d  = A;
                    b_d  = B;
                    case (op)
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            state_d = ST_MUL;
                            busy_d  = 1'b1;
                            cnt_d   = CNT_W'(MUL_CYCLES - 1);
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = ST_DIV_ITER;
                            busy_d  = 1'b1;
                            cnt_d   = CNT_W'(WIDTH - 1);
                            quo_d   = (issue_signed_s && A[WIDTH-1]) ? -A : A;
                            dvs_d   = (issue_signed_s && B[WIDTH-1]) ? -B : B;
                            rem_d   = '0;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                // Completion beats a same-edge flush.
                if (cnt_q == '0) begin
                    {hi_d, lo_d} = mul_res_s;
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
                end else if (flush) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DIV_ITER: begin
                if (flush) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    quo_d = {quo_q[WIDTH-2:0], ~trial_s[WIDTH]};
                    rem_d = trial_s[WIDTH] ? rem_shift_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
                    if (cnt_q == '0) begin
                        state_d = ST_DIV_FIX;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_DIV_FIX: begin
                if (b_q == '0) begin
                    lo_d = '1;
                    hi_d = a_q;
                end else if ((op_q == OP_DIV) && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1)) begin
                    lo_d = a_q;
                    hi_d = '0;
                end else begin
                    lo_d = quo_fix_s;
                    hi_d = rem_fix_s;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_md_unit_iter.sv
// Self-checking bench for md_unit_iter: directed corner cases plus randomized ops
// compared against an arithmetic HI/LO reference model.
module tb_md_unit_iter;
    localparam int W  = 32;
    localparam int MC = 5;

    logic         clk = 1'b0;
    logic         reset, start, flush, busy, done;
    logic [3:0]   op_i;
    logic [W-1:0] a_i, b_i, hi_o, lo_o;
    logic [W-1:0] m_hi, m_lo;
    int           n_checks = 0;
    int           n_fail   = 0;

    md_unit_iter #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op_i), .A(a_i), .B(b_i),
        .flush(flush), .busy(busy), .done(done), .HI(hi_o), .LO(lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] o);
        case (o)
            4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10: return MC;
            4'd5, 4'd6:                          return W + 1;
            default:                             return 0;
        endcase
    endfunction

    // Reference: architectural effect of one op on {HI,LO}.
    task automatic model_apply(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub, p, hl;
        int          si, sj;
        sa = $signed(a); sb = $signed(b);
        ua = {32'd0, a}; ub = {32'd0, b};
        hl = {m_hi, m_lo};
        case (o)
            4'd1: m_hi = a;
            4'd2: m_lo = a;
            4'd3, 4'd7, 4'd9, 4'd4, 4'd8, 4'd10: begin
                p = (o == 4'd4 || o == 4'd8 || o == 4'd10) ? ua * ub : 64'(sa * sb);
                if (o == 4'd7 || o == 4'd8)       hl = hl + p;
                else if (o == 4'd9 || o == 4'd10) hl = hl - p;
                else                              hl = p;
                {m_hi, m_lo} = hl;
            end
            4'd5, 4'd6: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = a;
                end else if (o == 4'd5 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = a; m_hi = 32'd0;
                end else if (o == 4'd5) begin
                    si = a; sj = b;
                    m_lo = si / sj; m_hi = si % sj;
                end else begin
                    m_lo = a / b; m_hi = a % b;
                end
            end
            default: ;
        endcase
    endtask

    // Issue at a falling edge, then watch latency, HI/LO hold and the done pulse.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] hi0, lo0;
        int lat, cyc;
        bit stable, done_early;
        hi0 = m_hi; lo0 = m_lo;
        lat = exp_lat(o);
        model_apply(o, a, b);
        start = 1'b1; op_i = o; a_i = a; b_i = b;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        cyc = 0; stable = 1'b1; done_early = 1'b0;
        while (busy && cyc < 200) begin
            cyc++;
            if (hi_o !== hi0 || lo_o !== lo0) stable = 1'b0;
            if (done) done_early = 1'b1;
            @(negedge clk);
        end
        check($sformatf("latency op%0d", o), 64'(cyc), 64'(lat));
        check($sformatf("done op%0d", o), {63'd0, done}, {63'd0, lat > 0});
        check($sformatf("HI op%0d a=%h b=%h", o, a, b), {32'd0, hi_o}, {32'd0, m_hi});
        check($sformatf("LO op%0d a=%h b=%h", o, a, b), {32'd0, lo_o}, {32'd0, m_lo});
        if (lat > 0) begin
            check("hold while busy", {63'd0, stable}, 64'd1);
            check("no early done", {63'd0, done_early}, 64'd0);
        end
    endtask

    // Flush during busy cycle k: cancels if k < latency, completion wins if k == latency.
    task automatic flush_at(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input int k);
        int lat;
        lat = exp_lat(o);
        if (k == lat) model_apply(o, a, b);
        start = 1'b1; op_i = o; a_i = a; b_i = b;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < k; i++) @(negedge clk);
        flush = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        check($sformatf("flush%0d busy", k), {63'd0, busy}, 64'd0);
        check($sformatf("flush%0d done", k), {63'd0, done}, {63'd0, k == lat});
        check($sformatf("flush%0d HI", k), {32'd0, hi_o}, {32'd0, m_hi});
        check($sformatf("flush%0d LO", k), {32'd0, lo_o}, {32'd0, m_lo});
        @(negedge clk);
        check($sformatf("flush%0d done after", k), {63'd0, done}, 64'd0);
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'(int'($urandom_range(0, 20)) - 10);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0]   ro;
        logic [W-1:0] ra, rb;
        int           cyc;
        reset = 1'b1; start = 1'b0; flush = 1'b0; op_i = 4'd0; a_i = '0; b_i = '0;
        m_hi = '0; m_lo = '0;
        @(negedge clk); @(negedge clk);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset HI", {32'd0, hi_o}, 64'd0);
        check("reset LO", {32'd0, lo_o}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(4'd3, 32'hFFFF_FFFE, 32'd3);
        check("mult const HI", {32'd0, hi_o}, 64'hFFFF_FFFF);
        check("mult const LO", {32'd0, lo_o}, 64'hFFFF_FFFA);
        run_op(4'd1, 32'd1, 32'd0);
        run_op(4'd2, 32'd0, 32'd0);
        run_op(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("maddu const HI", {32'd0, hi_o}, 64'hFFFF_FFFF);
        check("maddu const LO", {32'd0, lo_o}, 64'h0000_0001);
        run_op(4'd5, 32'hFFFF_FFF9, 32'd2);
        check("div const LO", {32'd0, lo_o}, 64'hFFFF_FFFD);
        check("div const HI", {32'd0, hi_o}, 64'hFFFF_FFFF);
        run_op(4'd6, 32'hFFFF_FFF9, 32'd2);
        check("divu const LO", {32'd0, lo_o}, 64'h7FFF_FFFC);
        check("divu const HI", {32'd0, hi_o}, 64'h1);
        run_op(4'd5, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div ovf LO", {32'd0, lo_o}, 64'h8000_0000);
        check("div ovf HI", {32'd0, hi_o}, 64'h0);
        run_op(4'd6, 32'd5, 32'd0);
        check("divu0 LO", {32'd0, lo_o}, 64'hFFFF_FFFF);
        check("divu0 HI", {32'd0, hi_o}, 64'h5);
        run_op(4'd5, 32'hFFFF_FFF0, 32'd0);

        flush_at(4'd5, 32'd1000, 32'd7, 10);
        flush_at(4'd5, 32'd1000, 32'd7, W);
        flush_at(4'd6, 32'd1000, 32'd7, W + 1);
        flush_at(4'd3, 32'd9, 32'd9, MC - 1);
        flush_at(4'd7, 32'd9, 32'd9, MC);

        // Start while busy must be ignored.
        model_apply(4'd6, 32'd100, 32'd9);
        start = 1'b1; op_i = 4'd6; a_i = 32'd100; b_i = 32'd9;
        @(posedge clk); @(negedge clk);
        op_i = 4'd2; a_i = 32'h1234_5678;
        @(negedge clk); @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 200) begin cyc++; @(negedge clk); end
        check("busy start latency", 64'(cyc + 2), 64'(W + 1));
        check("busy start LO", {32'd0, lo_o}, {32'd0, m_lo});
        check("busy start HI", {32'd0, hi_o}, {32'd0, m_hi});

        // Idle flush suppresses a same-edge start.
        start = 1'b1; flush = 1'b1; op_i = 4'd2; a_i = 32'hDEAD_BEEF;
        @(posedge clk); @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("idle flush LO", {32'd0, lo_o}, {32'd0, m_lo});
        check("idle flush busy", {63'd0, busy}, 64'd0);

        // Async reset between edges mid-divide.
        start = 1'b1; op_i = 4'd5; a_i = 32'd77; b_i = 32'd5;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async rst busy", {63'd0, busy}, 64'd0);
        check("async rst HI", {32'd0, hi_o}, 64'd0);
        check("async rst LO", {32'd0, lo_o}, 64'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op(4'd4, 32'd3, 32'd4);
        check("post rst LO", {32'd0, lo_o}, 64'd12);
        check("post rst HI", {32'd0, hi_o}, 64'd0);

        for (int n = 0; n < 60; n++) begin
            ro = 4'($urandom_range(0, 15));
            ra = rnd_operand();
            rb = rnd_operand();
            run_op(ro, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/md_unit_iter.md
Name: md_unit_iter

Overview:
Parametrised HI/LO multiply/divide unit for the EX stage, and the successor to the fixed-latency 32-bit unit.
- Multiply and multiply-accumulate finish after a programmable cycle count.
- Divide is a true iterative restoring divider producing one quotient bit per cycle.
- Defined results for divide-by-zero and signed overflow.
- A flush input cancels an in-flight operation when the issuing instruction is killed.
- Pipeline control stalls on busy for any later HI/LO access.

Parameters:
WIDTH, 32, operand/HI/LO width (even, >=8)
MUL_CYCLES, 5, busy cycles for MULT/MULTU/MADD/MADDU/MSUB/MSUBU (>=1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
start  in  1  issue request, sampled only when busy=0
op  in  4  0=NOP 1=MTHI 2=MTLO 3=MULT 4=MULTU 5=DIV 6=DIVU 7=MADD 8=MADDU 9=MSUB 10=MSUBU; 11-15 treated as NOP
A  in  WIDTH  forwarded GRF[rs] (dividend / multiplicand / MTHI-MTLO source)
B  in  WIDTH  forwarded GRF[rt] (divisor / multiplier)
flush  in  1  cancel in-flight operation
busy  out  1  operation in progress
done  out  1  one-cycle pulse on the edge HI/LO take a multi-cycle result
HI  out  WIDTH  HI register
LO  out  WIDTH  LO register

Behaviour:
- Reset (async, any time including mid-operation): HI=0, LO=0, busy=0, done=0, iteration counter=0, op latch=NOP. Partial results are discarded.
- States: IDLE, MUL, DIV_ITER, DIV_FIX.
- Issue: accepted at a rising edge only when busy=0 and start=1 and flush=0.
  - op, A and B are latched at that edge.
  - start while busy=1 is ignored; no queue, no error.
- MTHI/MTLO: HI (resp. LO) <= A at the accepting edge; busy stays 0; done stays 0.
- MUL path:
  - busy=1 for exactly MUL_CYCLES cycles after the accepting edge.
  - At the edge busy falls, {HI,LO} is written and done=1 for one cycle.
  - MULT/MULTU: {HI,LO} = A*B, signed or unsigned, 2*WIDTH bits.
  - MADD(U)/MSUB(U): {HI,LO} = {HI,LO} +/- A*B, modulo 2^(2*WIDTH). The HI/LO value used is the one at the accepting edge.
- DIV path:
  - DIV_ITER runs WIDTH cycles on operand magnitudes, restoring algorithm, one quotient bit per cycle, MSB first.
  - DIV_FIX takes 1 cycle and applies signs: quotient is negative iff operand signs differ (signed only); remainder takes the sign of the dividend.
  - busy=1 for WIDTH+1 cycles.
  - LO=quotient and HI=remainder are written at the edge busy falls; done pulses.
- Divide by zero (B=0, DIV or DIVU): full latency is still taken. LO = all ones, HI = A.
- Signed overflow (DIV, A = most-negative, B = -1): LO = A, HI = 0.
- Flush:
  - While busy=1: operation is abandoned at that edge; busy=0 next cycle; HI/LO unchanged; done not asserted.
  - With busy=0: a same-edge start is suppressed.
- Flush on the same edge as the completing edge: completion wins, HI/LO written and done pulses. Flush only cancels when at least one busy cycle remains.
- Start on the cycle after done is accepted normally, giving back-to-back operation.
- HI/LO are read combinationally and never change while busy=1.

Test Plan (WIDTH=32, MUL_CYCLES=5):
- MULT A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA, done for 1 cycle.
- MTHI 0x1, MTLO 0x0, then MADDU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles {HI,LO}=0x1_0000_0000 + 0xFFFFFFFE_00000001 = HI 0xFFFFFFFF, LO 0x00000001.
- DIV A=-7 (0xFFFFFFF9), B=2 -> busy 33 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU with the same operands -> LO=0x7FFFFFFC, HI=0x1.
- DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU A=5, B=0 -> LO=0xFFFFFFFF, HI=5, after 33 cycles.
- DIV issued, flush at busy cycle 10 -> busy low next cycle, HI/LO keep prior values, no done. Separately, start during busy with MTLO -> LO unchanged.
- Async reset asserted mid-DIV between clock edges -> busy, HI, LO = 0 immediately. After release, MULTU 3*4 -> LO=12, HI=0.
